// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: cache-miss freeze, branch redirect flushes and load-use
// bubbles, with saturating stall/flush event counters and a small redirect-tracking FSM.
module pipeline_hazard_ctrl #(
  parameter int         CNT_W    = 16,
  parameter logic [6:0] LOAD_OPC = 7'b0000011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             branch_taken,
  input  logic             id_ex_valid,
  input  logic             id_ex_rd_valid,
  input  logic [6:0]       id_ex_opcode,
  input  logic [4:0]       id_ex_rd_addr,
  input  logic             if_id_valid,
  input  logic             if_id_rs1_valid,
  input  logic             if_id_rs2_valid,
  input  logic [4:0]       if_id_rs1_addr,
  input  logic [4:0]       if_id_rs2_addr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FREEZE     = 2'd1,
    FLUSH_PEND = 2'd2,
    ILLEGAL    = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             pend_reg, pend_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic freeze_now;
  logic load_use;
  logic redirect;
  logic rs1_hit, rs2_hit;

  assign freeze_now = icache_stall | dcache_stall;
  assign rs1_hit    = if_id_rs1_valid & (if_id_rs1_addr == id_ex_rd_addr);
  assign rs2_hit    = if_id_rs2_valid & (if_id_rs2_addr == id_ex_rd_addr);
  assign load_use   = id_ex_valid & id_ex_rd_valid & (id_ex_opcode == LOAD_OPC)
                    & (id_ex_rd_addr != 5'd0) & if_id_valid & (rs1_hit | rs2_hit);
  assign redirect   = ~freeze_now & (((state_reg == RUN) & branch_taken)
                                     | (state_reg == FLUSH_PEND));

  // Priority: freeze > redirect > load-use > normal; everything quiet during reset.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    hazard_stall = 1'b0;
    if (rst_n && !freeze_now) begin
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (redirect) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        hazard_stall = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:        if (freeze_now) state_next = FREEZE;
      FREEZE:     if (!freeze_now) state_next = (pend_reg | branch_taken) ? FLUSH_PEND : RUN;
      FLUSH_PEND: state_next = RUN;
      default:    state_next = RUN;
    endcase
  end

  // A redirect seen while frozen is owed until the FLUSH_PEND cycle delivers it.
  always_comb begin
    pend_next = pend_reg | (freeze_now & branch_taken);
    if (state_reg == FLUSH_PEND) pend_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((freeze_now | hazard_stall) && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (if_id_flush && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign flush_events = flush_cnt_reg;
  assign state_out    = state_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a rule-level model checked every cycle on a 16-bit and a
// 4-bit counter instance, plus hand-computed literal checks on the directed scenarios.
module tb_pipeline_hazard_ctrl;
  localparam logic [6:0] LOAD = 7'b0000011;

  logic clk = 1'b0;
  logic rst_n;
  logic icache_stall, dcache_stall, branch_taken;
  logic id_ex_valid, id_ex_rd_valid;
  logic [6:0] id_ex_opcode;
  logic [4:0] id_ex_rd_addr;
  logic if_id_valid, if_id_rs1_valid, if_id_rs2_valid;
  logic [4:0] if_id_rs1_addr, if_id_rs2_addr;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, hazard_stall;
  logic [15:0] stall_cycles, flush_events;
  logic [1:0] state_out;
  logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic s_if_id_flush, s_id_ex_flush, s_hazard_stall;
  logic [3:0] s_stall_cycles, s_flush_events;
  logic [1:0] s_state_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .branch_taken(branch_taken), .id_ex_valid(id_ex_valid), .id_ex_rd_valid(id_ex_rd_valid),
    .id_ex_opcode(id_ex_opcode), .id_ex_rd_addr(id_ex_rd_addr), .if_id_valid(if_id_valid),
    .if_id_rs1_valid(if_id_rs1_valid), .if_id_rs2_valid(if_id_rs2_valid),
    .if_id_rs1_addr(if_id_rs1_addr), .if_id_rs2_addr(if_id_rs2_addr),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .hazard_stall(hazard_stall), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .state_out(state_out)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .branch_taken(branch_taken), .id_ex_valid(id_ex_valid), .id_ex_rd_valid(id_ex_rd_valid),
    .id_ex_opcode(id_ex_opcode), .id_ex_rd_addr(id_ex_rd_addr), .if_id_valid(if_id_valid),
    .if_id_rs1_valid(if_id_rs1_valid), .if_id_rs2_valid(if_id_rs2_valid),
    .if_id_rs1_addr(if_id_rs1_addr), .if_id_rs2_addr(if_id_rs2_addr),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
    .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .hazard_stall(s_hazard_stall), .stall_cycles(s_stall_cycles),
    .flush_events(s_flush_events), .state_out(s_state_out)
  );

  // Rule-level model: which FSM state we are in, whether a redirect is owed, raw event counts.
  int   m_state = 0;
  bit   m_owed  = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;
  bit   e_frz, e_lu, e_rdr, e_hs, e_fl;
  logic [4:0] e_en;
  logic [9:0] exp_ctl, got_big, got_small;
  int   exp_st_big, exp_st_small, exp_fl_big, exp_fl_small;

  always @(negedge clk) begin
    e_en = 5'b0; e_hs = 1'b0; e_fl = 1'b0;
    e_frz = 1'b0; e_lu = 1'b0; e_rdr = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_owed = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      e_frz = icache_stall || dcache_stall;
      e_lu  = id_ex_valid && id_ex_rd_valid && (id_ex_opcode == LOAD) && (id_ex_rd_addr != 0)
              && if_id_valid && ((if_id_rs1_valid && if_id_rs1_addr == id_ex_rd_addr)
                              || (if_id_rs2_valid && if_id_rs2_addr == id_ex_rd_addr));
      e_rdr = !e_frz && ((m_state == 0 && branch_taken) || m_state == 2);
      if (e_frz)      e_en = 5'b00000;
      else if (e_rdr) begin e_en = 5'b11111; e_fl = 1'b1; end
      else if (e_lu)  begin e_en = 5'b00111; e_hs = 1'b1; end
      else            e_en = 5'b11111;
    end
    exp_ctl   = {e_en, e_fl, e_fl, e_hs, 2'(m_state)};
    got_big   = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, hazard_stall, state_out};
    got_small = {s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en,
                 s_if_id_flush, s_id_ex_flush, s_hazard_stall, s_state_out};
    exp_st_big   = (m_stall > 65535) ? 65535 : m_stall;
    exp_fl_big   = (m_flush > 65535) ? 65535 : m_flush;
    exp_st_small = (m_stall > 15) ? 15 : m_stall;
    exp_fl_small = (m_flush > 15) ? 15 : m_flush;
    n_vec += 4;
    if (got_big !== exp_ctl) begin
      n_err++;
      $display("FAIL ctl_w16 t=%0t got=%b exp=%b", $time, got_big, exp_ctl);
    end
    if (got_small !== exp_ctl) begin
      n_err++;
      $display("FAIL ctl_w4 t=%0t got=%b exp=%b", $time, got_small, exp_ctl);
    end
    if (int'(stall_cycles) != exp_st_big || int'(flush_events) != exp_fl_big) begin
      n_err++;
      $display("FAIL cnt_w16 t=%0t got stall=%0d flush=%0d exp stall=%0d flush=%0d",
               $time, stall_cycles, flush_events, exp_st_big, exp_fl_big);
    end
    if (int'(s_stall_cycles) != exp_st_small || int'(s_flush_events) != exp_fl_small) begin
      n_err++;
      $display("FAIL cnt_w4 t=%0t got stall=%0d flush=%0d exp stall=%0d flush=%0d",
               $time, s_stall_cycles, s_flush_events, exp_st_small, exp_fl_small);
    end
    if (rst_n) begin
      if (e_frz || e_hs) m_stall++;
      if (e_fl) m_flush++;
      if (m_state == 2) m_owed = 1'b0;
      else m_owed = m_owed || (e_frz && branch_taken);
      case (m_state)
        0:       m_state = e_frz ? 1 : 0;
        1:       m_state = e_frz ? 1 : ((m_owed || branch_taken) ? 2 : 0);
        default: m_state = 0;
      endcase
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end else
      $display("ok   %s t=%0t value=%0d", name, $time, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    icache_stall = 0; dcache_stall = 0; branch_taken = 0;
    id_ex_valid = 0; id_ex_rd_valid = 0; id_ex_opcode = 7'd0; id_ex_rd_addr = 5'd0;
    if_id_valid = 0; if_id_rs1_valid = 0; if_id_rs2_valid = 0;
    if_id_rs1_addr = 5'd0; if_id_rs2_addr = 5'd0;
  endtask

  task automatic set_lu(input logic [6:0] opc, input logic [4:0] rd, input logic idv,
                        input logic [4:0] rs1, input logic v1, input logic [4:0] rs2,
                        input logic v2);
    id_ex_valid = 1; id_ex_rd_valid = 1; id_ex_opcode = opc; id_ex_rd_addr = rd;
    if_id_valid = idv; if_id_rs1_addr = rs1; if_id_rs1_valid = v1;
    if_id_rs2_addr = rs2; if_id_rs2_valid = v2;
  endtask

  typedef struct {
    logic [6:0] opc; logic [4:0] rd; logic idv;
    logic [4:0] rs1; logic v1; logic [4:0] rs2; logic v2; int hs;
  } lu_vec_t;

  lu_vec_t lu_tab[6];
  int st;

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    lu_tab[0] = '{LOAD,        5'd7,  1, 5'd7,  1, 5'd0, 0, 1};
    lu_tab[1] = '{LOAD,        5'd7,  1, 5'd7,  0, 5'd7, 0, 0};
    lu_tab[2] = '{LOAD,        5'd7,  1, 5'd3,  1, 5'd7, 1, 1};
    lu_tab[3] = '{7'b0110011,  5'd7,  1, 5'd7,  1, 5'd7, 1, 0};
    lu_tab[4] = '{LOAD,        5'd7,  0, 5'd7,  1, 5'd7, 1, 0};
    lu_tab[5] = '{LOAD,        5'd31, 1, 5'd31, 1, 5'd0, 0, 1};

    // Reset with hostile inputs: every output must stay quiet.
    clr(); rst_n = 0; branch_taken = 1; icache_stall = 1;
    set_lu(LOAD, 5'd5, 1, 5'd5, 1, 5'd5, 1);
    tick(); tick();
    chk("rst_pc_en", int'(pc_en), 0);
    chk("rst_flush", int'(if_id_flush), 0);
    chk("rst_state", int'(state_out), 0);
    chk("rst_stall_cnt", int'(stall_cycles), 0);
    clr(); rst_n = 1;
    tick();

    // Load x5 feeding rs2.
    set_lu(LOAD, 5'd5, 1, 5'd3, 1, 5'd5, 1);
    #1;
    chk("lu_pc_en", int'(pc_en), 0);
    chk("lu_if_id_en", int'(if_id_en), 0);
    chk("lu_id_ex_en", int'(id_ex_en), 1);
    chk("lu_hazard", int'(hazard_stall), 1);
    tick(); clr();
    chk("lu_stall_cnt", int'(stall_cycles), 1);
    st = 1;

    // Load to x0 never stalls.
    set_lu(LOAD, 5'd0, 1, 5'd0, 1, 5'd0, 0);
    #1;
    chk("x0_hazard", int'(hazard_stall), 0);
    chk("x0_pc_en", int'(pc_en), 1);
    tick(); clr();

    foreach (lu_tab[i]) begin
      set_lu(lu_tab[i].opc, lu_tab[i].rd, lu_tab[i].idv, lu_tab[i].rs1, lu_tab[i].v1,
             lu_tab[i].rs2, lu_tab[i].v2);
      #1;
      chk($sformatf("lu_tab%0d_hazard", i), int'(hazard_stall), lu_tab[i].hs);
      st += lu_tab[i].hs;
      tick(); clr();
    end
    chk("lu_tab_stall_cnt", int'(stall_cycles), st);

    // Redirect in RUN.
    branch_taken = 1;
    #1;
    chk("br_if_id_flush", int'(if_id_flush), 1);
    chk("br_id_ex_flush", int'(id_ex_flush), 1);
    chk("br_pc_en", int'(pc_en), 1);
    tick(); clr();
    chk("br_flush_cnt", int'(flush_events), 1);
    #1;
    chk("br_flush_drop", int'(if_id_flush), 0);

    // 4-cycle dcache freeze with branch pulsed in its second cycle.
    dcache_stall = 1;
    #1;
    chk("frz_pc_en", int'(pc_en), 0);
    chk("frz_mem_wb_en", int'(mem_wb_en), 0);
    tick(); branch_taken = 1;
    tick(); branch_taken = 0;
    tick(); tick(); dcache_stall = 0;
    chk("frz_state_drop", int'(state_out), 1);
    chk("frz_stall_cnt", int'(stall_cycles), st + 4);
    st += 4;
    #1;
    chk("frz_drop_pc_en", int'(pc_en), 1);
    chk("frz_drop_flush", int'(if_id_flush), 0);
    tick();
    chk("frz_state_pend", int'(state_out), 2);
    #1;
    chk("pend_flush", int'(id_ex_flush), 1);
    chk("pend_pc_en", int'(pc_en), 1);
    tick();
    chk("pend_state_run", int'(state_out), 0);
    chk("pend_flush_cnt", int'(flush_events), 2);

    // icache freeze beats load-use; the load-use bubble follows once freeze drops.
    icache_stall = 1;
    set_lu(LOAD, 5'd9, 1, 5'd9, 1, 5'd0, 0);
    #1;
    chk("ic_lu_hazard", int'(hazard_stall), 0);
    chk("ic_lu_id_ex_en", int'(id_ex_en), 0);
    tick(); tick(); icache_stall = 0;
    #1;
    chk("ic_after_hazard", int'(hazard_stall), 1);
    chk("ic_after_pc_en", int'(pc_en), 0);
    tick(); clr();
    st += 3;
    chk("ic_stall_cnt", int'(stall_cycles), st);

    // Branch held across a whole freeze gives one redirect.
    dcache_stall = 1; branch_taken = 1;
    tick(); tick(); tick(); dcache_stall = 0;
    #1;
    chk("hold_drop_flush", int'(if_id_flush), 0);
    tick(); branch_taken = 0;
    #1;
    chk("hold_pend_flush", int'(if_id_flush), 1);
    tick();
    chk("hold_flush_cnt", int'(flush_events), 3);
    tick();
    chk("hold_flush_cnt2", int'(flush_events), 3);
    st += 3;

    // Long freeze saturates the 4-bit counter; reset mid-freeze drops the owed redirect.
    dcache_stall = 1;
    repeat (20) tick();
    chk("sat_stall_w4", int'(s_stall_cycles), 15);
    chk("sat_stall_w16", int'(stall_cycles), st + 20);
    branch_taken = 1;
    tick();
    rst_n = 0;
    #1;
    chk("midrst_state", int'(state_out), 0);
    chk("midrst_stall_w4", int'(s_stall_cycles), 0);
    chk("midrst_flush_w16", int'(flush_events), 0);
    chk("midrst_pc_en", int'(pc_en), 0);
    tick(); rst_n = 1; branch_taken = 0; dcache_stall = 0;
    #1;
    chk("post_rst_flush", int'(if_id_flush), 0);
    chk("post_rst_pc_en", int'(pc_en), 1);
    tick();
    chk("post_rst_state", int'(state_out), 0);
    chk("post_rst_flush_cnt", int'(flush_events), 0);

    // Reset while in FLUSH_PEND.
    dcache_stall = 1; branch_taken = 1;
    tick(); dcache_stall = 0; branch_taken = 0;
    tick();
    chk("fp_state", int'(state_out), 2);
    rst_n = 0;
    #1;
    chk("fp_rst_flush", int'(if_id_flush), 0);
    tick(); rst_n = 1;
    #1;
    chk("fp_post_flush", int'(if_id_flush), 0);
    tick();
    chk("fp_post_cnt", int'(flush_events), 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
